mdu_div_seq: RTL and testbench

- Iterative radix-2 restoring divider for the RV32 M-extension: DIV, DIVU, REM, REMU.
- Sits beside the combinational alu in the EX stage. The pipeline control issues a divide op over a valid/ready handshake. The result returns over a second valid/ready handshake, and EX stalls in between.
- Uses the same 5-bit SELECT encoding as the ALU.

---
 rtl/mdu_div_seq_pkg.sv | 25 ++
 rtl/mdu_div_seq_div_step.sv | 23 ++
 rtl/mdu_div_seq.sv | 116 +++++++++++
 tb/tb_mdu_div_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_div_seq_pkg.sv
// Shared definitions for the sequential M-extension divider: op codes (shared with the alu),
// FSM state encoding and the per-operation control captured on accept.
package mdu_div_seq_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [4:0] ALU_DIV  = 5'b01100;
   localparam logic [4:0] ALU_DIVU = 5'b01101;
   localparam logic [4:0] ALU_REM  = 5'b01110;
   localparam logic [4:0] ALU_REMU = 5'b01111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   // Everything about the op that is still needed after the operands are made positive
   typedef struct packed {
      logic is_rem;
      logic neg_q;
      logic neg_r;
   } div_op_t;

endpackage

// File: rtl/mdu_div_seq_div_step.sv
// One restoring division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_nxt,
   output logic [XLEN-1:0] quo_nxt
);

   // One extra bit: rem < divisor can still exceed 2^(XLEN-1), so the shift may carry out
   logic [XLEN:0] sh;
   logic [XLEN:0] diff;
   logic          ge;

   assign sh      = {rem, quo[XLEN-1]};
   assign diff    = sh - {1'b0, divisor};
   assign ge      = ~diff[XLEN];
   assign rem_nxt = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
   assign quo_nxt = {quo[XLEN-2:0], ge};

endmodule

// File: rtl/mdu_div_seq.sv
// Iterative radix-2 restoring divider (DIV/DIVU/REM/REMU) with valid/ready in and out.
// Optional MDU_DIV_KILL_EN adds a kill input that abandons an in-flight op.
module mdu_div_seq
   import mdu_div_seq_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] data1,
   input  logic [XLEN-1:0] data2,
   input  logic [4:0]      select,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
`ifdef MDU_DIV_KILL_EN
   ,
   input  logic            kill
`endif
);

   div_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0] rem_q, quo_q, dvsr_q;
   logic [XLEN-1:0] rem_nxt, quo_nxt;
   logic [XLEN-1:0] rem_fix, quo_fix;
   div_op_t         op_q, op_d;

   logic            is_sgn, div0, ovf, special, accept, last, kill_w;
   logic [XLEN-1:0] abs1, abs2, special_res;
   logic            unused_sel;

`ifdef MDU_DIV_KILL_EN
   assign kill_w = kill;
`else
   assign kill_w = 1'b0;
`endif

   // Only SELECT[1:0] decides the op; the upper bits are the shared alu prefix
   assign unused_sel = ^select[4:2];
   assign is_sgn     = ~select[0];
   assign op_d.is_rem = select[1];
   assign op_d.neg_q  = is_sgn & (data1[XLEN-1] ^ data2[XLEN-1]);
   assign op_d.neg_r  = is_sgn & data1[XLEN-1];

   assign abs1 = (is_sgn && data1[XLEN-1]) ? -data1 : data1;
   assign abs2 = (is_sgn && data2[XLEN-1]) ? -data2 : data2;

   assign div0    = (data2 == '0);
   assign ovf     = is_sgn && (data1 == {1'b1, {(XLEN-1){1'b0}}}) && (data2 == '1);
   assign special = div0 | ovf;
   assign special_res = div0 ? (op_d.is_rem ? data1 : '1)
                             : (op_d.is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}});

   assign accept = in_valid && (state == IDLE);
   assign last   = (state == CALC) && (cnt == CNT_W'(XLEN-1));

   div_step #(.XLEN(XLEN)) u_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .divisor (dvsr_q),
      .rem_nxt (rem_nxt),
      .quo_nxt (quo_nxt)
   );

   assign quo_fix = op_q.neg_q ? -quo_nxt : quo_nxt;
   assign rem_fix = op_q.neg_r ? -rem_nxt : rem_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = special ? DONE : CALC;
         CALC:    if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (kill_w && (state != IDLE)) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         rem_q  <= '0;
         quo_q  <= '0;
         dvsr_q <= '0;
         op_q   <= '0;
         result <= '0;
      end else if (accept) begin
         cnt    <= '0;
         rem_q  <= '0;
         quo_q  <= abs1;
         dvsr_q <= abs2;
         op_q   <= op_d;
         if (special) result <= special_res;
      end else if (state == CALC) begin
         rem_q <= rem_nxt;
         quo_q <= quo_nxt;
         cnt   <= cnt + CNT_W'(1);
         if (last) result <= op_q.is_rem ? rem_fix : quo_fix;
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mdu_div_seq.sv
// Scoreboard bench for mdu_div_seq: expected results queued on issue, popped on OUT_VALID.
module tb_mdu_div_seq;
   import mdu_div_seq_pkg::*;

   logic        clk = 1'b0;
   logic        reset, in_valid, out_ready;
   logic [31:0] data1, data2, result;
   logic [4:0]  select;
   logic        in_ready, out_valid, busy;
`ifdef MDU_DIV_KILL_EN
   logic        kill;
`endif

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q [$];

   typedef struct {
      logic [4:0]  sel;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
      int          lat;
   } vec_t;

   always #5 clk = ~clk;

   mdu_div_seq dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data1     (data1),
      .data2     (data2),
      .select    (select),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
`ifdef MDU_DIV_KILL_EN
      ,
      .kill      (kill)
`endif
   );

   // Present a request and return #1 after the edge that accepts it
   task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input bit push);
      int n;
      data1 = a; data2 = b; select = sel; in_valid = 1'b1;
      if (push) exp_q.push_back(e);
      n = 0;
      while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Edges counted from the accept edge (=1) until OUT_VALID is seen
   task automatic collect(output logic [31:0] r, output int lat, output bit to);
      lat = 1;
      while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
      to = !out_valid;
      r  = result;
   endtask

   task automatic test_reset;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      data1 = '0; data2 = '0; select = ALU_DIV;
`ifdef MDU_DIV_KILL_EN
      kill = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
      total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
   endtask

   task automatic test_ops;
      vec_t v [0:17];
      logic [31:0] r, e;
      int lat;
      bit to;
      v = '{
         '{ALU_DIV,  32'd7,        32'd2,        32'd3,        33},
         '{ALU_REM,  32'd7,        32'd2,        32'd1,        33},
         '{ALU_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33},
         '{ALU_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33},
         '{ALU_DIVU, 32'hFFFFFFFE, 32'd2,        32'h7FFFFFFF, 33},
         '{ALU_REMU, 32'hFFFFFFFF, 32'h10,       32'hF,        33},
         '{ALU_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 33},
         '{ALU_REM,  32'd100,      32'hFFFFFFF9, 32'd2,        33},
         '{ALU_DIVU, 32'hFFFFFFFF, 32'h80000001, 32'd1,        33},
         '{ALU_REMU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33},
         '{ALU_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1},
         '{ALU_REM,  32'd5,        32'd0,        32'd5,        1},
         '{ALU_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1},
         '{ALU_REMU, 32'h0000DEAD, 32'd0,        32'h0000DEAD, 1},
         '{ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
         '{ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        1},
         '{ALU_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33},
         '{ALU_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33}
      };
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin
         issue(v[i].sel, v[i].a, v[i].b, v[i].e, 1'b1);
         collect(r, lat, to);
         e = exp_q.pop_front();
         total++; if (to || r !== e) begin bad++; $display("FAIL op%0d_result got=%h want=%h timeout=%0d", i, r, e, to); end
         total++; if (lat !== v[i].lat) begin bad++; $display("FAIL op%0d_latency got=%0d want=%0d", i, lat, v[i].lat); end
         total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL op%0d_done_flags in_ready=%b busy=%b want 0/1", i, in_ready, busy); end
         @(posedge clk); #1;
         total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL op%0d_release out_valid=%b in_ready=%b want 0/1", i, out_valid, in_ready); end
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] r, e;
      int lat, stable_bad;
      bit to;
      out_ready = 1'b0;
      issue(ALU_DIV, 32'd7, 32'd2, 32'd3, 1'b1);
      collect(r, lat, to);
      e = exp_q.pop_front();
      total++; if (to || r !== e) begin bad++; $display("FAIL bp_result got=%h want=%h timeout=%0d", r, e, to); end
      data1 = 32'd100; data2 = 32'd7; select = ALU_DIVU; in_valid = 1'b1;
      exp_q.push_back(32'd14);
      stable_bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (result !== e || in_ready !== 1'b0 || out_valid !== 1'b1) stable_bad++;
      end
      total++; if (stable_bad !== 0) begin bad++; $display("FAIL bp_hold bad_cycles=%0d want=0", stable_bad); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_queued_accept busy=%b want=1", busy); end
      collect(r, lat, to);
      e = exp_q.pop_front();
      total++; if (to || r !== e || lat !== 33) begin bad++; $display("FAIL bp_queued_result got=%h lat=%0d want=%h lat=33", r, lat, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [31:0] r, e;
      int lat, n;
      bit to;
      out_ready = 1'b1;
      issue(ALU_DIVU, 32'd1000, 32'd10, 32'd100, 1'b1);
      collect(r, lat, to);
      e = exp_q.pop_front();
      total++; if (to || r !== e) begin bad++; $display("FAIL b2b_first got=%h want=%h", r, e); end
      data1 = 32'd1001; data2 = 32'd10; select = ALU_REMU; in_valid = 1'b1;
      exp_q.push_back(32'd1);
      n = 0;
      while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1; n++;
      in_valid = 1'b0;
      // accept-to-accept distance is lat (33) + n - 1 edges
      total++; if (lat + n - 1 !== 34) begin bad++; $display("FAIL b2b_period got=%0d want=34", lat + n - 1); end
      collect(r, lat, to);
      e = exp_q.pop_front();
      total++; if (to || r !== e) begin bad++; $display("FAIL b2b_second got=%h want=%h", r, e); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      logic [31:0] r, e;
      int lat, seen;
      bit to;
      out_ready = 1'b1;
      issue(ALU_DIV, 32'd12345, 32'd67, 32'd0, 1'b0);
      repeat (14) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || result !== 32'h0) begin
         bad++; $display("FAIL midreset_state out_valid=%b in_ready=%b busy=%b result=%h want 0/1/0/0", out_valid, in_ready, busy, result);
      end
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
      total++; if (seen !== 0) begin bad++; $display("FAIL midreset_no_output got=%0d want=0", seen); end
      issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
      collect(r, lat, to);
      e = exp_q.pop_front();
      total++; if (to || r !== e) begin bad++; $display("FAIL midreset_next got=%h want=%h", r, e); end
      @(posedge clk); #1;
   endtask

`ifdef MDU_DIV_KILL_EN
   task automatic test_kill;
      logic [31:0] r, e;
      int lat, seen;
      bit to;
      out_ready = 1'b1;
      issue(ALU_DIV, 32'd1000, 32'd3, 32'd0, 1'b0);
      repeat (9) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1 kill = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL kill_calc out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
      total++; if (seen !== 0) begin bad++; $display("FAIL kill_no_output got=%0d want=0", seen); end
      out_ready = 1'b0;
      issue(ALU_DIV, 32'd9, 32'd3, 32'd3, 1'b1);
      collect(r, lat, to);
      e = exp_q.pop_front();
      total++; if (to || r !== e) begin bad++; $display("FAIL kill_pre_done got=%h want=%h", r, e); end
      kill = 1'b1;
      @(posedge clk); #1 kill = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL kill_done out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
      out_ready = 1'b1;
      kill = 1'b1;
      issue(ALU_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
      kill = 1'b0;
      collect(r, lat, to);
      e = exp_q.pop_front();
      total++; if (to || r !== e) begin bad++; $display("FAIL kill_idle_accept got=%h want=%h", r, e); end
      @(posedge clk); #1;
   endtask
`endif

   initial begin
      test_reset();
      test_ops();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef MDU_DIV_KILL_EN
      test_kill();
`endif
      total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
